// File: rtl/xyolo_write.sv
`default_nettype none
// ============================================================================
// xyolo_write: captures a result stream into a ping-pong buffer and drains
// the filled half to external memory through a Versat databus write port.
// Optional feature macro: XYOLO_WRITE_PREFETCH_EN (1 word/cycle drain).
// Revision: 1.0
// ============================================================================
module xyolo_write #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                run,
    output logic                done,
    input  logic                valid,
    input  logic [1:0]          addr,
    input  logic [ADDR_W-1:0]   wdata,
    input  logic                wstrb,
    input  logic [DATA_W-1:0]   flow_in,
    input  logic                flow_in_en,
    input  logic                databus_ready,
    output logic                databus_valid,
    output logic [ADDR_W-1:0]   databus_addr,
    input  logic [DATA_W-1:0]   databus_rdata,
    output logic [DATA_W-1:0]   databus_wdata,
    output logic [DATA_W/8-1:0] databus_wstrb
);

    localparam int c_HALF_W = MEM_ADDR_W - 1;
    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_DEPTH  = 1 << MEM_ADDR_W;
    localparam logic [ADDR_W-1:0] c_LEN_MAX = ADDR_W'(1) << c_HALF_W;
`ifdef XYOLO_WRITE_PREFETCH_EN
    localparam bit c_PREFETCH = 1'b1;
`else
    localparam bit c_PREFETCH = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_W-1:0]     r_mem [0:c_DEPTH-1];
    logic                  r_fill_sel;
    logic [c_HALF_W-1:0]   r_fill_ptr;

    logic [ADDR_W-1:0]     r_ext_addr;
    logic [MEM_ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0]     r_stride;

    logic [MEM_ADDR_W-1:0] r_sh_len;
    logic [ADDR_W-1:0]     r_sh_stride;
    logic [ADDR_W-1:0]     r_cur_addr;
    logic                  r_drain_sel;
    logic [c_HALF_W-1:0]   r_drain_ptr;
    logic [MEM_ADDR_W-1:0] r_cnt;

    logic                  r_valid;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_done;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_advance;
    logic [ADDR_W-1:0]     w_next_addr;
    logic [c_HALF_W-1:0]   w_rd_ptr;
    logic [MEM_ADDR_W-1:0] w_rd_idx;
    logic                  w_unused_rdata;

    assign w_start     = run && (r_state == S_IDLE);
    assign w_accept    = (r_state == S_SEND) && databus_ready;
    assign w_last      = (r_cnt == (r_sh_len - 1'b1));
    assign w_advance   = w_accept && !w_last;
    assign w_next_addr = r_cur_addr + r_sh_stride;
    // READ fetches the current word; an accept in SEND fetches the one after it.
    assign w_rd_ptr    = (r_state == S_READ) ? r_drain_ptr : (r_drain_ptr + 1'b1);
    assign w_rd_idx    = {r_drain_sel, w_rd_ptr};
    assign w_unused_rdata = ^databus_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext_addr <= '0;
            r_len      <= '0;
            r_stride   <= '0;
        end else if (clear) begin
            r_ext_addr <= '0;
            r_len      <= '0;
            r_stride   <= '0;
        end else if (valid && wstrb) begin
            case (addr)
                2'd0: r_ext_addr <= wdata;
                2'd1: r_len      <= (wdata > c_LEN_MAX) ? c_LEN_MAX[MEM_ADDR_W-1:0]
                                                        : wdata[MEM_ADDR_W-1:0];
                2'd2: r_stride   <= wdata;
                default: ;
            endcase
        end
    end

    // A write in the same cycle as an accepted run lands in the old half.
    always_ff @(posedge clk) begin
        if (flow_in_en) begin
            r_mem[{r_fill_sel, r_fill_ptr}] <= flow_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill_sel <= 1'b0;
            r_fill_ptr <= '0;
        end else if (w_start) begin
            r_fill_sel <= ~r_fill_sel;
            r_fill_ptr <= '0;
        end else if (flow_in_en) begin
            r_fill_ptr <= r_fill_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (run && (r_len != '0)) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: w_state_next = S_SEND;
            S_SEND: begin
                if (databus_ready) begin
                    if (w_last) begin
                        w_state_next = S_IDLE;
                    end else if (c_PREFETCH) begin
                        w_state_next = S_SEND;
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_len    <= '0;
            r_sh_stride <= '0;
            r_cur_addr  <= '0;
            r_drain_sel <= 1'b0;
            r_drain_ptr <= '0;
            r_cnt       <= '0;
        end else if (w_start) begin
            r_sh_len    <= r_len;
            r_sh_stride <= r_stride;
            r_cur_addr  <= r_ext_addr;
            r_drain_sel <= r_fill_sel;
            r_drain_ptr <= '0;
            r_cnt       <= '0;
        end else if (w_advance) begin
            r_drain_ptr <= r_drain_ptr + 1'b1;
            r_cnt       <= r_cnt + 1'b1;
            r_cur_addr  <= w_next_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b1;
        end else begin
            r_done <= (w_state_next == S_IDLE);
            if (r_state == S_READ) begin
                r_valid <= 1'b1;
                r_addr  <= r_cur_addr;
                r_wdata <= r_mem[w_rd_idx];
            end else if (w_accept) begin
                if (c_PREFETCH && !w_last) begin
                    r_addr  <= w_next_addr;
                    r_wdata <= r_mem[w_rd_idx];
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign done          = r_done;
    assign databus_valid = r_valid;
    assign databus_addr  = r_addr;
    assign databus_wdata = r_wdata;
    assign databus_wstrb = {c_STRB_W{r_valid}};

endmodule
`default_nettype wire

// File: tb/tb_xyolo_write.sv
`default_nettype none
// ============================================================================
// tb_xyolo_write: table-driven and hand-sequenced bench for xyolo_write with a
// scoreboard of expected databus writes.
// Revision: 1.0
// ============================================================================
module tb_xyolo_write;

`ifdef XYOLO_WRITE_PREFETCH_EN
    localparam int c_GAP = 1;
`else
    localparam int c_GAP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic        wstrb = 1'b0;
    logic [31:0] flow_in = '0;
    logic        flow_in_en = 1'b0;
    logic        databus_ready = 1'b1;
    logic [31:0] databus_rdata = '0;
    logic        done;
    logic        databus_valid;
    logic [31:0] databus_addr;
    logic [31:0] databus_wdata;
    logic [3:0]  databus_wstrb;

    always #5 clk = ~clk;

    xyolo_write #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .run           (run),
        .done          (done),
        .valid         (valid),
        .addr          (addr),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .flow_in       (flow_in),
        .flow_in_en    (flow_in_en),
        .databus_ready (databus_ready),
        .databus_valid (databus_valid),
        .databus_addr  (databus_addr),
        .databus_rdata (databus_rdata),
        .databus_wdata (databus_wdata),
        .databus_wstrb (databus_wstrb)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        logic [31:0] ext, len, stride, base, step;
        int          n;
        logic [31:0] last;
    } vec_t;

    exp_t        sb [$];
    int          acc_cyc [$];
    vec_t        tbl [6];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          run_cyc = 0;
    int          run_seq = 0;
    int          seen_seq = 0;
    int          n_acc = 0;
    int          n_stall = 0;
    int          last_acc_cyc = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] hold_a = '0;
    logic [31:0] hold_d = '0;
    bit          stall_prev = 1'b0;
    bit          watch_done = 1'b0;
    logic        done_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, stall stability, latency and done timing.
    always @(negedge clk) begin
        exp_t e;
        if (stall_prev) begin
            chk("hold_valid", 64'(databus_valid), 64'd1);
            chk("hold_addr", 64'(databus_addr), 64'(hold_a));
            chk("hold_data", 64'(databus_wdata), 64'(hold_d));
        end
        stall_prev = databus_valid && !databus_ready && rst;
        if (stall_prev) n_stall++;
        hold_a = databus_addr;
        hold_d = databus_wdata;
        if ((run_seq != seen_seq) && databus_valid) begin
            chk("run_to_valid", 64'(cyc - run_cyc), 64'd2);
            seen_seq = run_seq;
        end
        if (databus_valid && databus_ready) begin
            n_acc++;
            last_acc_cyc = cyc;
            last_addr = databus_addr;
            acc_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                         databus_addr, databus_wdata);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(databus_addr), 64'(e.a));
                chk("wr_data", 64'(databus_wdata), 64'(e.d));
                chk("wr_strb", 64'(databus_wstrb), 64'hF);
            end
        end
        if (watch_done && done && !done_prev) begin
            chk("done_rise_delay", 64'(cyc - last_acc_cyc), 64'd1);
        end
        done_prev = done;
    end

    task automatic cfg(input logic [1:0] a, input logic [31:0] d);
        valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        valid = 1'b0; wstrb = 1'b0;
    endtask

    task automatic push_words(input logic [31:0] base, input logic [31:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            flow_in_en = 1'b1;
            flow_in = base + step * 32'(i);
            @(posedge clk); #1;
        end
        flow_in_en = 1'b0;
    endtask

    task automatic exp_push(input logic [31:0] ext, input logic [31:0] stride,
                            input logic [31:0] base, input logic [31:0] step, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.a = ext + stride * 32'(i);
            e.d = base + step * 32'(i);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_run(input bit expect_start);
        run = 1'b1;
        if (expect_start) begin
            run_cyc = cyc;
            run_seq++;
        end
        @(posedge clk); #1;
        run = 1'b0;
        if (expect_start) chk("done_low_after_run", 64'(done), 64'd0);
    endtask

    // Per-cycle driver while a drain is in progress: optional ready stall,
    // concurrent fill words and a run pulse while busy.
    task automatic drain_wait(input int hold_idx, input int hold_n, input int push_n,
                              input logic [31:0] push_base, input logic [31:0] push_step,
                              input int busy_it, input int budget);
        int acc0 = n_acc;
        int held = 0;
        int it = 0;
        while (it < budget) begin
            if (done && !databus_valid && it >= push_n) break;
            databus_ready = 1'b1;
            if ((n_acc - acc0) == hold_idx && databus_valid && held < hold_n) begin
                databus_ready = 1'b0;
                held++;
            end
            flow_in_en = (it < push_n);
            flow_in = push_base + push_step * 32'(it);
            run = (it == busy_it);
            @(posedge clk); #1;
            it++;
        end
        databus_ready = 1'b1;
        flow_in_en = 1'b0;
        run = 1'b0;
        if (it >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk(name, 64'({done, databus_valid}), 64'b10);
        end
    endtask

    initial begin
        int g;
        tbl[0] = '{32'h1000,     32'd4,   32'd4,        32'h11,       32'h11,    4,   32'h100C};
        tbl[1] = '{32'h2000,     32'd1,   32'd8,        32'hDEADBEEF, 32'd1,     1,   32'h2000};
        tbl[2] = '{32'hFFFFFFF8, 32'd4,   32'd4,        32'h1234,     32'h101,   4,   32'h4};
        tbl[3] = '{32'h0,        32'd600, 32'd4,        32'd3,        32'd7,     512, 32'h7FC};
        tbl[4] = '{32'h100,      32'd3,   32'd0,        32'h5A5A0000, 32'h10001, 3,   32'h100};
        tbl[5] = '{32'h10,       32'd2,   32'hFFFFFFFC, 32'hABCD0000, 32'd5,     2,   32'hC};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 64'(done), 64'd1);
        chk("rst_valid", 64'(databus_valid), 64'd0);
        chk("rst_addr", 64'(databus_addr), 64'd0);
        chk("rst_wdata", 64'(databus_wdata), 64'd0);
        chk("rst_wstrb", 64'(databus_wstrb), 64'd0);
        rst = 1'b1;
        watch_done = 1'b1;

        // Basic drain
        cfg(2'd0, 32'h1000); cfg(2'd1, 32'd4); cfg(2'd2, 32'd4);
        push_words(32'h11, 32'h11, 4);
        exp_push(32'h1000, 32'd4, 32'h11, 32'h11, 4);
        pulse_run(1'b1);
        drain_wait(-1, 0, 0, '0, '0, -1, 200);
        chk("basic_empty", 64'(sb.size()), 64'd0);
        chk("basic_last", 64'(last_addr), 64'h100C);

        // Back-pressure on word 2
        n_stall = 0;
        push_words(32'h11, 32'h11, 4);
        exp_push(32'h1000, 32'd4, 32'h11, 32'h11, 4);
        pulse_run(1'b1);
        drain_wait(1, 3, 0, '0, '0, -1, 200);
        chk("bp_empty", 64'(sb.size()), 64'd0);
        chk("bp_stalls", 64'(n_stall), 64'd3);

        // Ping-pong with concurrent fill and an ignored busy run
        push_words(32'h11, 32'h11, 4);
        exp_push(32'h1000, 32'd4, 32'h11, 32'h11, 4);
        pulse_run(1'b1);
        drain_wait(-1, 0, 4, 32'hA0, 32'd1, 3, 200);
        chk("pp1_empty", 64'(sb.size()), 64'd0);
        cfg(2'd0, 32'h2000);
        exp_push(32'h2000, 32'd4, 32'hA0, 32'd1, 4);
        pulse_run(1'b1);
        drain_wait(-1, 0, 0, '0, '0, -1, 200);
        chk("pp2_empty", 64'(sb.size()), 64'd0);
        chk("pp2_last", 64'(last_addr), 64'h200C);

        // LEN=0 flips halves without any transfer
        push_words(32'hBAD0, 32'd1, 2);
        cfg(2'd1, 32'd0);
        pulse_run(1'b0);
        idle_check("len0_idle", 5);
        push_words(32'h600D0, 32'd1, 2);
        cfg(2'd0, 32'h4000); cfg(2'd1, 32'd2);
        exp_push(32'h4000, 32'd4, 32'h600D0, 32'd1, 2);
        pulse_run(1'b1);
        drain_wait(-1, 0, 0, '0, '0, -1, 100);
        cfg(2'd0, 32'h4100);
        exp_push(32'h4100, 32'd4, 32'hBAD0, 32'd1, 2);
        pulse_run(1'b1);
        drain_wait(-1, 0, 0, '0, '0, -1, 100);
        chk("len0_flip_empty", 64'(sb.size()), 64'd0);

        // Clear zeroes config so a run does nothing
        cfg(2'd0, 32'h7000); cfg(2'd1, 32'd5); cfg(2'd2, 32'd8);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        pulse_run(1'b0);
        idle_check("clear_idle", 4);

        // Table-driven drains
        for (int i = 0; i < 6; i++) begin
            cfg(2'd0, tbl[i].ext); cfg(2'd1, tbl[i].len); cfg(2'd2, tbl[i].stride);
            push_words(tbl[i].base, tbl[i].step, tbl[i].n);
            exp_push(tbl[i].ext, tbl[i].stride, tbl[i].base, tbl[i].step, tbl[i].n);
            pulse_run(1'b1);
            drain_wait(-1, 0, 0, '0, '0, -1, 4 * tbl[i].n + 50);
            chk("tbl_empty", 64'(sb.size()), 64'd0);
            chk("tbl_last", 64'(last_addr), 64'(tbl[i].last));
        end

        // Throughput
        cfg(2'd0, 32'h9000); cfg(2'd1, 32'd8); cfg(2'd2, 32'd4);
        push_words(32'h900, 32'd3, 8);
        exp_push(32'h9000, 32'd4, 32'h900, 32'd3, 8);
        acc_cyc.delete();
        pulse_run(1'b1);
        drain_wait(-1, 0, 0, '0, '0, -1, 100);
        chk("thru_count", 64'(acc_cyc.size()), 64'd8);
        for (int k = 1; k < acc_cyc.size(); k++) begin
            chk("thru_gap", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(c_GAP));
        end

        // Asynchronous reset mid-drain
        cfg(2'd0, 32'h3000); cfg(2'd1, 32'd4); cfg(2'd2, 32'd4);
        push_words(32'h3300, 32'd1, 4);
        exp_push(32'h3000, 32'd4, 32'h3300, 32'd1, 4);
        g = n_acc;
        pulse_run(1'b1);
        begin
            int w = 0;
            while (!((n_acc - g) >= 1 && databus_valid) && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            chk("rst_wait_in_time", 64'(w < 50), 64'd1);
        end
        watch_done = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(databus_valid), 64'd0);
        chk("arst_done", 64'(done), 64'd1);
        chk("arst_addr", 64'(databus_addr), 64'd0);
        chk("arst_wstrb", 64'(databus_wstrb), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        watch_done = 1'b1;
        cfg(2'd0, 32'h5000); cfg(2'd1, 32'd2); cfg(2'd2, 32'h10);
        push_words(32'hC0DE0000, 32'd1, 2);
        exp_push(32'h5000, 32'h10, 32'hC0DE0000, 32'd1, 2);
        pulse_run(1'b1);
        drain_wait(-1, 0, 0, '0, '0, -1, 100);
        chk("post_rst_empty", 64'(sb.size()), 64'd0);
        chk("post_rst_last", 64'(last_addr), 64'h5010);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xyolo_write.md
Name: xyolo_write

Overview:
- Stream-to-memory write engine: the opposite direction of the YOLO vector read path.
- Captures a single-lane result flow from the compute array into an internal ping-pong buffer.
- On each `run`, flips the buffer halves and drains the previously filled half to external memory through a Versat databus write initiator.
- Sits at the output of the convolution datapath, feeding the external-memory interconnect.

Parameters:
- DATA_W, 32: flow and databus data width.
- ADDR_W, 32: external (databus) byte-address width; also CPU wdata width.
- MEM_ADDR_W, 10: internal buffer address width. Each ping-pong half holds 2^(MEM_ADDR_W-1) words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of configuration registers.
- run  in  1  single-cycle start/flip pulse.
- done  out  1  high when idle.
- valid  in  1  CPU config request.
- addr  in  2  config register select.
- wdata  in  ADDR_W  config write data.
- wstrb  in  1  config write enable.
- flow_in  in  DATA_W  result word from datapath.
- flow_in_en  in  1  flow_in is valid this cycle.
- databus_ready  in  1  write accepted.
- databus_valid  out  1  write request.
- databus_addr  out  ADDR_W  byte address.
- databus_rdata  in  DATA_W  unused, ignored.
- databus_wdata  out  DATA_W  write data.
- databus_wstrb  out  DATA_W/8  byte strobes.

Behaviour:
- Reset and interface decisions: one clock; reset is asynchronous and active-low. While rst=0 the following hold:
  - databus_valid, databus_addr, databus_wdata and databus_wstrb are 0.
  - done=1 and FSM=IDLE.
  - fill_sel=0, fill_ptr=0, all config and shadow registers 0.
- Config registers are written when valid&wstrb. `clear` zeroes them only; it does not touch the FSM or the buffer.
  - addr 0: EXT_ADDR, ADDR_W bits.
  - addr 1: LEN, MEM_ADDR_W bits. Values above 2^(MEM_ADDR_W-1) saturate to 2^(MEM_ADDR_W-1).
  - addr 2: STRIDE, ADDR_W bits, byte increment per word.
- Fill side:
  - Each flow_in_en cycle writes flow_in to buffer address {fill_sel, fill_ptr}, then fill_ptr++.
  - fill_ptr wraps to 0 at the half size, overwriting.
  - Fill is independent of drain and allowed at any time.
- Run while IDLE:
  - Shadow EXT_ADDR, LEN and STRIDE.
  - Set drain half = fill_sel, toggle fill_sel, reset fill_ptr=0.
  - If LEN=0, stay IDLE with done=1 and issue no transactions. Otherwise go to READ next cycle and set done=0.
- Run while busy is ignored: no shadow update, no flip.
- Simultaneous flow_in_en and run: the word is written to the old fill half at old fill_ptr, then the flip takes effect.
- FSM:
  - IDLE: waits for run as above.
  - READ: issue a synchronous buffer read at {drain_sel, drain_ptr}, then go to SEND.
  - SEND: databus_valid=1 with databus_wdata = read data and databus_addr = cur_addr, databus_wstrb = all ones. All outputs are held stable until databus_ready.
  - On ready with cnt = LEN-1: go to IDLE; done rises in the following cycle.
  - On ready otherwise: drain_ptr++, cnt++, cur_addr += STRIDE (modulo 2^ADDR_W, wrap silently), then go to READ.
- databus_valid never drops without ready.
- cur_addr starts at shadow EXT_ADDR.
- Minimum throughput: 2 cycles per word.
- Outputs are registered. Latency from run to first databus_valid is 2 cycles.

Optional Feature:
- Macro: XYOLO_WRITE_PREFETCH_EN.
- Defined: a one-word prefetch register sits in front of the databus outputs.
  - While in SEND, the next word is read from the buffer.
  - On ready with words remaining, databus_valid stays 1 and the outputs advance to the next word in the same cycle.
  - Throughput is 1 word/cycle; run-to-first-valid is still 2 cycles.
- Undefined: the 2-cycle-per-word READ/SEND loop above is used and the prefetch register is absent.

Test Plan:
- Basic drain:
  - Stimulus: push 0x11,0x22,0x33,0x44; EXT_ADDR=0x1000, LEN=4, STRIDE=4; run; ready tied 1.
  - Response: writes to 0x1000/0x1004/0x1008/0x100C with data 0x11..0x44, wstrb=0xF, done=0 throughout, done=1 one cycle after the last accept.
- Back-pressure:
  - Stimulus: same setup, with ready held 0 for 3 cycles during word 2.
  - Response: valid=1, addr=0x1004, wdata=0x22 stable across all 3 cycles; sequence otherwise unchanged.
- Ping-pong:
  - Stimulus: during the drain, push 0xA0..0xA3; second run with EXT_ADDR=0x2000.
  - Response: second run writes 0xA0..0xA3 to 0x2000..0x200C; the first run's data is intact.
- LEN=0 and busy run:
  - Stimulus: run with LEN=0; then, separately, a run pulse mid-drain.
  - Response: LEN=0 run gives no databus_valid, done stays 1, halves flip. Mid-drain run changes neither address sequence nor fill_sel.
- Reset mid-drain:
  - Stimulus: assert rst=0 at word 2.
  - Response: databus_valid=0 immediately (asynchronous), done=1. After release, a new 2-word run writes correctly starting at the new EXT_ADDR.
- Throughput:
  - Stimulus: LEN=8, ready=1.
  - Response: with XYOLO_WRITE_PREFETCH_EN, 8 accepts in 8 consecutive cycles. Without the macro, 8 accepts spaced 2 cycles apart.
